// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: register address, FIFO entry, zero register.
package wb_pkg;
  localparam int WB_XLEN = 32;

  typedef logic [4:0] regaddr_t;

  localparam regaddr_t REG_ZERO = 5'd0;

  typedef struct packed {
    regaddr_t             rd;
    logic [WB_XLEN-1:0]   wd;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency results; DEPTH must be a power of two so
// the pointers wrap by plain overflow.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  entry_t din_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);
  localparam int AW = $clog2(DEPTH);

  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: in-order pipeline wins the regfile port, buffered
// long-latency results drain otherwise; pend tracks outstanding destinations.
// Optional WB_BYPASS_EN: same-cycle write of a long-latency result when idle.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_we,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_wd,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_wd,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            busy,
  output logic            we3,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3,
  output logic [31:0]     pend
);
  typedef struct packed {
    regaddr_t        rd;
    logic [XLEN-1:0] wd;
  } entry_t;

  entry_t      fifo_head, fifo_din;
  logic        fifo_full, fifo_empty, fifo_push;
  logic        pipe_wr, drain, bypass;
  logic        clr_valid;
  regaddr_t    clr_rd;
  logic [31:0] pend_q, pend_d;

  wb_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (drain),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  function automatic logic hazard(regaddr_t r, logic [31:0] p, logic cv, regaddr_t cr);
    return (r != REG_ZERO) && p[r] && !(cv && (cr == r));
  endfunction

  always_comb begin
    pipe_wr  = pipe_we && (pipe_rd != REG_ZERO);
    lu_ready = !reset && !fifo_full;
    drain    = !reset && !pipe_wr && !fifo_empty;
    bypass   = 1'b0;
`ifdef WB_BYPASS_EN
    bypass   = !reset && !pipe_wr && fifo_empty && lu_valid && (lu_rd != REG_ZERO);
`endif
    fifo_push   = lu_valid && lu_ready && (lu_rd != REG_ZERO) && !bypass;
    fifo_din.rd = lu_rd;
    fifo_din.wd = lu_wd;

    we3 = 1'b0;
    a3  = REG_ZERO;
    wd3 = '0;
    if (!reset && pipe_wr) begin
      we3 = 1'b1;
      a3  = pipe_rd;
      wd3 = pipe_wd;
    end else if (drain) begin
      we3 = 1'b1;
      a3  = fifo_head.rd;
      wd3 = fifo_head.wd;
    end else if (bypass) begin
      we3 = 1'b1;
      a3  = lu_rd;
      wd3 = lu_wd;
    end

    clr_valid = drain || bypass;
    clr_rd    = bypass ? lu_rd : fifo_head.rd;

    // Clear first so a same-cycle issue to the same register wins.
    pend_d = pend_q;
    if (clr_valid) pend_d[clr_rd] = 1'b0;
    if (iss_valid && (iss_rd != REG_ZERO)) pend_d[iss_rd] = 1'b1;
    pend_d[0] = 1'b0;

    busy = !reset && (hazard(chk_rs1, pend_q, clr_valid, clr_rd) ||
                      hazard(chk_rs2, pend_q, clr_valid, clr_rd) ||
                      hazard(chk_rd,  pend_q, clr_valid, clr_rd));
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign pend = pend_q;

  iss_no_reissue: assert property (@(posedge clk) disable iff (reset)
    (iss_valid && (iss_rd != REG_ZERO)) |-> !pend_q[iss_rd]);
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: hand vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset, pipe_we, lu_valid, iss_valid;
  logic [4:0]      pipe_rd, lu_rd, iss_rd, chk_rs1, chk_rs2, chk_rd;
  logic [XLEN-1:0] pipe_wd, lu_wd;
  logic            lu_ready, busy, we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;
  logic [31:0]     pend;

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_wd(lu_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .chk_rd(chk_rd), .busy(busy), .we3(we3), .a3(a3), .wd3(wd3), .pend(pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            reset;
    logic            pipe_we;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_wd;
    logic            lu_valid;
    logic [4:0]      lu_rd;
    logic [XLEN-1:0] lu_wd;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      rs1, rs2, rd;
  } vec_t;

  typedef struct {
    vec_t            in;
    logic            we3;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
    logic            busy;
    logic            ready;
    logic [31:0]     pend;
  } tv_t;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
  } res_t;

  int checks = 0;
  int errors = 0;

  // Reference model state: buffered results in arrival order, pending set.
  res_t            m_q[$];
  bit              m_pend[32];
  logic            e_we, e_busy, e_ready;
  logic [4:0]      e_a3;
  logic [XLEN-1:0] e_wd3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v.reset = 0; v.pipe_we = 0; v.pipe_rd = 0; v.pipe_wd = 0;
    v.lu_valid = 0; v.lu_rd = 0; v.lu_wd = 0;
    v.iss_valid = 0; v.iss_rd = 0; v.rs1 = 0; v.rs2 = 0; v.rd = 0;
    return v;
  endfunction

  function automatic logic [31:0] model_pend();
    logic [31:0] p = '0;
    for (int i = 1; i < 32; i++) p[i] = m_pend[i];
    return p;
  endfunction

  // Drive one cycle, compare against the model, then advance the model.
  task automatic apply(input vec_t v);
    bit drained, bypassed, cleared;
    logic [4:0] clr;
    logic [4:0] regs[3];
    @(negedge clk);
    reset = v.reset; pipe_we = v.pipe_we; pipe_rd = v.pipe_rd; pipe_wd = v.pipe_wd;
    lu_valid = v.lu_valid; lu_rd = v.lu_rd; lu_wd = v.lu_wd;
    iss_valid = v.iss_valid; iss_rd = v.iss_rd;
    chk_rs1 = v.rs1; chk_rs2 = v.rs2; chk_rd = v.rd;
    #1;
    drained = 0; bypassed = 0; clr = 0;
    e_we = 0; e_a3 = 0; e_wd3 = 0;
    e_ready = !v.reset && (m_q.size() < DEPTH);
    if (!v.reset) begin
      if (v.pipe_we && v.pipe_rd != 0) begin
        e_we = 1; e_a3 = v.pipe_rd; e_wd3 = v.pipe_wd;
      end else if (m_q.size() > 0) begin
        e_we = 1; e_a3 = m_q[0].rd; e_wd3 = m_q[0].wd; drained = 1; clr = m_q[0].rd;
      end
`ifdef WB_BYPASS_EN
      else if (v.lu_valid && v.lu_rd != 0) begin
        e_we = 1; e_a3 = v.lu_rd; e_wd3 = v.lu_wd; bypassed = 1; clr = v.lu_rd;
      end
`endif
    end
    cleared = drained || bypassed;
    regs[0] = v.rs1; regs[1] = v.rs2; regs[2] = v.rd;
    e_busy = 0;
    if (!v.reset)
      foreach (regs[k])
        if (regs[k] != 0 && m_pend[regs[k]] && !(cleared && clr == regs[k])) e_busy = 1;
    chk("m_we3", {31'd0, we3}, {31'd0, e_we});
    if (e_we) begin
      chk("m_a3", {27'd0, a3}, {27'd0, e_a3});
      chk("m_wd3", wd3, e_wd3);
    end
    chk("m_busy", {31'd0, busy}, {31'd0, e_busy});
    chk("m_ready", {31'd0, lu_ready}, {31'd0, e_ready});
    chk("m_pend", pend, model_pend());
    if (v.reset) begin
      m_q.delete();
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      if (drained) void'(m_q.pop_front());
      if (v.lu_valid && e_ready && v.lu_rd != 0 && !bypassed) m_q.push_back('{v.lu_rd, v.lu_wd});
      if (cleared) m_pend[clr] = 0;
      if (v.iss_valid && v.iss_rd != 0) m_pend[v.iss_rd] = 1;
    end
  endtask

  tv_t  tbl[7];
  vec_t v;

  initial begin
    foreach (m_pend[i]) m_pend[i] = 0;
    v = idle(); v.reset = 1;
    apply(v); apply(v);

    // Issue rd=5, result three cycles later, rs1=5 watched throughout.
    foreach (tbl[i]) begin
      tbl[i].in = idle(); tbl[i].in.rs1 = 5;
      tbl[i].we3 = 0; tbl[i].a3 = 0; tbl[i].wd3 = 0;
      tbl[i].busy = 0; tbl[i].ready = 1; tbl[i].pend = 32'h20;
    end
    tbl[0].in.rs1 = 0; tbl[0].pend = 0;
    tbl[1].in.iss_valid = 1; tbl[1].in.iss_rd = 5; tbl[1].pend = 0;
    tbl[2].busy = 1;
    tbl[3].busy = 1;
    tbl[4].in.lu_valid = 1; tbl[4].in.lu_rd = 5; tbl[4].in.lu_wd = 32'h1234;
`ifdef WB_BYPASS_EN
    tbl[4].we3 = 1; tbl[4].a3 = 5; tbl[4].wd3 = 32'h1234;
    tbl[5].pend = 0;
`else
    tbl[4].busy = 1;
    tbl[5].we3 = 1; tbl[5].a3 = 5; tbl[5].wd3 = 32'h1234;
`endif
    tbl[6].pend = 0;
    foreach (tbl[i]) begin
      apply(tbl[i].in);
      chk($sformatf("t%0d_we3", i), {31'd0, we3}, {31'd0, tbl[i].we3});
      if (tbl[i].we3) begin
        chk($sformatf("t%0d_a3", i), {27'd0, a3}, {27'd0, tbl[i].a3});
        chk($sformatf("t%0d_wd3", i), wd3, tbl[i].wd3);
      end
      chk($sformatf("t%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("t%0d_ready", i), {31'd0, lu_ready}, {31'd0, tbl[i].ready});
      chk($sformatf("t%0d_pend", i), pend, tbl[i].pend);
    end

    // Fill the FIFO while the pipeline holds the port, then drain in order.
    for (int i = 0; i < 4; i++) begin
      v = idle(); v.pipe_we = 1; v.pipe_rd = 10; v.pipe_wd = i;
      v.lu_valid = 1; v.lu_rd = 5'(i + 1); v.lu_wd = 32'hA0 + i;
      apply(v);
      chk("fill_ready", {31'd0, lu_ready}, 32'd1);
    end
    v = idle(); v.pipe_we = 1; v.pipe_rd = 10; v.pipe_wd = 32'h55;
    apply(v);
    chk("full_ready", {31'd0, lu_ready}, 32'd0);
    chk("full_a3", {27'd0, a3}, 32'd10);
    for (int i = 0; i < 4; i++) begin
      apply(idle());
      chk("drain_a3", {27'd0, a3}, i + 1);
      chk("drain_wd3", wd3, 32'hA0 + i);
      chk("drain_ready", {31'd0, lu_ready}, (i == 0) ? 32'd0 : 32'd1);
    end
    apply(idle());
    chk("drained_we3", {31'd0, we3}, 32'd0);

    // Pipeline rd=7 and FIFO head rd=9 compete in the same cycle.
    v = idle(); v.pipe_we = 1; v.pipe_rd = 11; v.pipe_wd = 1;
    v.lu_valid = 1; v.lu_rd = 9; v.lu_wd = 32'h99;
    apply(v);
    v = idle(); v.pipe_we = 1; v.pipe_rd = 7; v.pipe_wd = 32'h77;
    apply(v);
    chk("pri_a3", {27'd0, a3}, 32'd7);
    chk("pri_wd3", wd3, 32'h77);
    apply(idle());
    chk("pri_next_a3", {27'd0, a3}, 32'd9);
    chk("pri_next_wd3", wd3, 32'h99);

    // Writes to x0 from both sources are dropped.
    v = idle(); v.pipe_we = 1; v.pipe_rd = 0; v.pipe_wd = 32'h5;
    v.lu_valid = 1; v.lu_rd = 0; v.lu_wd = 32'h6;
    apply(v);
    chk("zero_we3", {31'd0, we3}, 32'd0);
    chk("zero_ready", {31'd0, lu_ready}, 32'd1);
    apply(idle());
    chk("zero_next_we3", {31'd0, we3}, 32'd0);
    chk("zero_pend", pend, 32'd0);

    // Randomized traffic; issues avoid destinations already pending.
    for (int n = 0; n < 600; n++) begin
      v = idle();
      v.reset    = ($urandom_range(0, 49) == 0);
      v.pipe_we  = $urandom_range(0, 1);
      v.pipe_rd  = 5'($urandom_range(0, 12));
      v.pipe_wd  = $urandom;
      v.lu_valid = ($urandom_range(0, 2) != 0);
      v.lu_rd    = 5'($urandom_range(0, 12));
      v.lu_wd    = $urandom;
      v.iss_rd   = 5'($urandom_range(0, 12));
      v.iss_valid = ($urandom_range(0, 2) == 0) && !m_pend[v.iss_rd];
      v.rs1 = 5'($urandom_range(0, 12));
      v.rs2 = 5'($urandom_range(0, 12));
      v.rd  = 5'($urandom_range(0, 12));
      apply(v);
    end

    // Reset with three buffered results and pend[3], pend[4] set.
    v = idle(); v.reset = 1;
    apply(v); apply(v);
    for (int i = 0; i < 3; i++) begin
      v = idle(); v.pipe_we = 1; v.pipe_rd = 12; v.pipe_wd = i;
      v.lu_valid = 1; v.lu_rd = 5'(3 + i); v.lu_wd = 32'hC0 + i;
      v.iss_valid = (i < 2); v.iss_rd = 5'(3 + i);
      apply(v);
    end
    chk("pre_rst_pend", pend, 32'h18);
    v = idle(); v.reset = 1; v.rs1 = 3;
    apply(v);
    chk("rst_we3", {31'd0, we3}, 32'd0);
    chk("rst_ready", {31'd0, lu_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    v = idle(); v.rs1 = 3; v.rs2 = 4;
    apply(v);
    chk("post_rst_pend", pend, 32'd0);
    chk("post_rst_we3", {31'd0, we3}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_ready", {31'd0, lu_ready}, 32'd1);
    apply(idle());
    chk("post_rst_we3_2", {31'd0, we3}, 32'd0);

`ifdef WB_BYPASS_EN
    v = idle(); v.lu_valid = 1; v.lu_rd = 6; v.lu_wd = 32'h66;
    apply(v);
    chk("byp_we3", {31'd0, we3}, 32'd1);
    chk("byp_a3", {27'd0, a3}, 32'd6);
    chk("byp_wd3", wd3, 32'h66);
    apply(idle());
    chk("byp_next_we3", {31'd0, we3}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
